// File: rtl/inert_seq.sv
// SPI inertial-sensor sequencer: power-up wait, programmable configuration writes,
// then per-INT burst read of NUM_CH 16-bit channels published atomically on vld.
module inert_seq #(
    parameter int unsigned            NUM_CH    = 5,
    parameter int unsigned            NUM_INIT  = 4,
    parameter logic [NUM_INIT*16-1:0] INIT_CMDS = {16'h0D02, 16'h1062, 16'h1162, 16'h1460},
    parameter logic [7:0]             BASE_ADDR = 8'hA2,
    parameter int unsigned            TMR_W     = 16,
    parameter int unsigned            TO_W      = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   INT,
    input  logic                   reinit,
    input  logic                   done,
    input  logic [7:0]             rd_data,
    output logic                   wrt,
    output logic [15:0]            cmd,
    output logic [NUM_CH*16-1:0]   data,
    output logic                   vld,
    output logic                   init_done,
    output logic                   timeout
);

    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_INIT - 1);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(2 * NUM_CH - 1);

    typedef enum logic [2:0] {
        WAIT_PWR  = 3'd0,
        INIT_WR   = 3'd1,
        INIT_BUSY = 3'd2,
        IDLE      = 3'd3,
        RD_BUSY   = 3'd4
    } state_t;

    // Entry 0 of the write list sits in the MSBs.
    function automatic logic [15:0] init_cmd(input logic [IDX_W-1:0] idx);
        logic [15:0] c;
        c = 16'h0000;
        for (int j = 0; j < int'(NUM_INIT); j++) begin
            c = (idx == IDX_W'(j)) ? INIT_CMDS[(int'(NUM_INIT) - 1 - j)*16 +: 16] : c;
        end
        return c;
    endfunction

    // Byte b lands at bits [8b+7:8b], so even bytes are channel lows and odd bytes highs.
    function automatic logic [NUM_CH*16-1:0] put_byte(input logic [NUM_CH*16-1:0] s,
                                                      input logic [IDX_W-1:0]    idx,
                                                      input logic [7:0]          v);
        logic [NUM_CH*16-1:0] r;
        r = s;
        for (int k = 0; k < 2 * int'(NUM_CH); k++) begin
            r[8*k +: 8] = (idx == IDX_W'(k)) ? v : s[8*k +: 8];
        end
        return r;
    endfunction

    state_t                 state_q,       state_d;
    logic [TMR_W-1:0]       tmr_q,         tmr_d;
    logic [TO_W-1:0]        wdog_q,        wdog_d;
    logic [IDX_W-1:0]       init_idx_q,    init_idx_d;
    logic [IDX_W-1:0]       byte_idx_q,    byte_idx_d;
    logic [NUM_CH*16-1:0]   stage_q,       stage_d;
    logic [NUM_CH*16-1:0]   data_q,        data_d;
    logic                   vld_q,         vld_d;
    logic                   init_done_q,   init_done_d;
    logic                   timeout_q,     timeout_d;
    logic                   reinit_pend_q, reinit_pend_d;
    logic                   int_meta_q;
    logic                   int_s_q;

    logic                   reinit_now_s;
    logic                   do_reinit_s;
    logic                   wrt_s;
    logic [15:0]            cmd_s;
    logic [7:0]             rd_addr_s;

    assign reinit_now_s = reinit_pend_q | reinit;
    assign rd_addr_s    = BASE_ADDR + {{(8-IDX_W){1'b0}}, byte_idx_q};

    // Two-flop synchroniser for the asynchronous data-ready level.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
        end
    end

    // Next-state, transaction issue and frame assembly.
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        wdog_d        = {TO_W{1'b0}};
        init_idx_d    = init_idx_q;
        byte_idx_d    = byte_idx_q;
        stage_d       = stage_q;
        data_d        = data_q;
        vld_d         = 1'b0;
        init_done_d   = init_done_q;
        timeout_d     = timeout_q;
        reinit_pend_d = reinit_now_s;
        do_reinit_s   = 1'b0;
        wrt_s         = 1'b0;
        cmd_s         = init_cmd({IDX_W{1'b0}});

        case (state_q)
            WAIT_PWR: begin
                cmd_s = init_cmd({IDX_W{1'b0}});
                if (reinit_now_s) begin
                    do_reinit_s = 1'b1;
                end else if (&tmr_q) begin
                    wrt_s      = 1'b1;
                    tmr_d      = {TMR_W{1'b0}};
                    init_idx_d = {IDX_W{1'b0}};
                    state_d    = INIT_BUSY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            INIT_BUSY: begin
                cmd_s = init_cmd(init_idx_q);
                if (done) begin
                    if (reinit_now_s) begin
                        do_reinit_s = 1'b1;
                    end else if (init_idx_q < LAST_INIT) begin
                        wrt_s      = 1'b1;
                        cmd_s      = init_cmd(init_idx_q + IDX_W'(1));
                        init_idx_d = init_idx_q + IDX_W'(1);
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    state_d = INIT_BUSY;
                end
            end

            IDLE: begin
                cmd_s     = {BASE_ADDR, 8'h00};
                wdog_d    = wdog_q + TO_W'(1);
                timeout_d = timeout_q | (&wdog_q);
                if (reinit_now_s) begin
                    do_reinit_s = 1'b1;
                end else if (int_s_q) begin
                    wrt_s      = 1'b1;
                    byte_idx_d = {IDX_W{1'b0}};
                    state_d    = RD_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end

            RD_BUSY: begin
                cmd_s = {rd_addr_s, 8'h00};
                if (done) begin
                    stage_d = put_byte(stage_q, byte_idx_q, rd_data);
                    if (byte_idx_q < LAST_BYTE) begin
                        if (reinit_now_s) begin
                            do_reinit_s = 1'b1;
                        end else begin
                            wrt_s      = 1'b1;
                            cmd_s      = {rd_addr_s + 8'h01, 8'h00};
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end else begin
                        // A re-init landing on the last byte still publishes the frame.
                        data_d = stage_d;
                        vld_d  = 1'b1;
                        if (reinit_now_s) begin
                            do_reinit_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    stage_d = stage_q;
                end
            end

            INIT_WR: begin
                do_reinit_s = 1'b1;
            end

            default: begin
                do_reinit_s = 1'b1;
            end
        endcase

        state_d       = do_reinit_s ? WAIT_PWR           : state_d;
        tmr_d         = do_reinit_s ? {TMR_W{1'b0}}      : tmr_d;
        wdog_d        = do_reinit_s ? {TO_W{1'b0}}       : wdog_d;
        init_idx_d    = do_reinit_s ? {IDX_W{1'b0}}      : init_idx_d;
        byte_idx_d    = do_reinit_s ? {IDX_W{1'b0}}      : byte_idx_d;
        init_done_d   = do_reinit_s ? 1'b0               : init_done_d;
        timeout_d     = do_reinit_s ? 1'b0               : timeout_d;
        reinit_pend_d = do_reinit_s ? 1'b0               : reinit_pend_d;
    end

    // Sequencer state and published-frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_PWR;
            tmr_q         <= {TMR_W{1'b0}};
            wdog_q        <= {TO_W{1'b0}};
            init_idx_q    <= {IDX_W{1'b0}};
            byte_idx_q    <= {IDX_W{1'b0}};
            stage_q       <= {(NUM_CH*16){1'b0}};
            data_q        <= {(NUM_CH*16){1'b0}};
            vld_q         <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_q     <= 1'b0;
            reinit_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            wdog_q        <= wdog_d;
            init_idx_q    <= init_idx_d;
            byte_idx_q    <= byte_idx_d;
            stage_q       <= stage_d;
            data_q        <= data_d;
            vld_q         <= vld_d;
            init_done_q   <= init_done_d;
            timeout_q     <= timeout_d;
            reinit_pend_q <= reinit_pend_d;
        end
    end

    assign wrt       = wrt_s;
    assign cmd       = cmd_s;
    assign data      = data_q;
    assign vld       = vld_q;
    assign init_done = init_done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_inert_seq.sv
// Directed bench for inert_seq: a 5-channel instance and a 2-channel address-wrap instance,
// each served by a simple SPI master model that answers 10 cycles after wrt.
module tb_inert_seq;

    logic        clk = 1'b0;
    logic        rst, int_1, reinit, int_2;
    logic        done, wrt, vld, init_done, timeout;
    logic [7:0]  rd_data;
    logic [15:0] cmd;
    logic [79:0] data;
    logic        done2, wrt2, vld2, init_done2, timeout2;
    logic [7:0]  rd_data2;
    logic [15:0] cmd2;
    logic [31:0] data2;

    logic [7:0]  seed;
    int          n_total = 0;
    int          n_bad   = 0;

    logic [15:0] log1 [128];
    logic [15:0] log2 [32];
    int          wr_n  = 0;
    int          wr2_n = 0;
    int          vld_n = 0;
    int          cnt1  = 0;
    int          cnt2  = 0;
    logic [7:0]  addr1, addr2;

    logic [15:0] exp_init [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

    always #5 clk = ~clk;

    inert_seq #(
        .NUM_CH(5), .NUM_INIT(4), .INIT_CMDS(64'h0D02_1062_1162_1460),
        .BASE_ADDR(8'hA2), .TMR_W(4), .TO_W(6)
    ) u_dut (
        .clk(clk), .rst(rst), .INT(int_1), .reinit(reinit), .done(done),
        .rd_data(rd_data), .wrt(wrt), .cmd(cmd), .data(data), .vld(vld),
        .init_done(init_done), .timeout(timeout)
    );

    inert_seq #(
        .NUM_CH(2), .NUM_INIT(4), .INIT_CMDS(64'h0D02_1062_1162_1460),
        .BASE_ADDR(8'hFE), .TMR_W(4), .TO_W(6)
    ) u_dut2 (
        .clk(clk), .rst(rst), .INT(int_2), .reinit(1'b0), .done(done2),
        .rd_data(rd_data2), .wrt(wrt2), .cmd(cmd2), .data(data2), .vld(vld2),
        .init_done(init_done2), .timeout(timeout2)
    );

    // SPI master models: the sensor answers each read address with (addr - first_addr + 1 + seed).
    always @(posedge clk) begin
        done  <= 1'b0;
        done2 <= 1'b0;
        if (rst) begin
            cnt1 <= 0;
            cnt2 <= 0;
        end else begin
            if (wrt === 1'b1) begin
                cnt1  <= 9;
                addr1 <= cmd[15:8];
            end else if (cnt1 != 0) begin
                cnt1 <= cnt1 - 1;
                if (cnt1 == 1) begin
                    done    <= 1'b1;
                    rd_data <= addr1 - 8'hA1 + seed;
                end
            end
            if (wrt2 === 1'b1) begin
                cnt2  <= 9;
                addr2 <= cmd2[15:8];
            end else if (cnt2 != 0) begin
                cnt2 <= cnt2 - 1;
                if (cnt2 == 1) begin
                    done2    <= 1'b1;
                    rd_data2 <= addr2 - 8'hFD;
                end
            end
        end
    end

    // Transaction and frame monitor.
    always @(posedge clk) begin
        if (wrt === 1'b1 && wr_n < 128) begin
            log1[wr_n] <= cmd;
            wr_n       <= wr_n + 1;
        end
        if (wrt2 === 1'b1 && wr2_n < 32) begin
            log2[wr2_n] <= cmd2;
            wr2_n       <= wr2_n + 1;
        end
        if (vld === 1'b1) vld_n <= vld_n + 1;
    end

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_wrt(output int n);
        n = 0;
        while (wrt !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, init_done, 1'b1);
    endtask

    task automatic wait_done_n(input int k, input string tag);
        int seen;
        int n;
        seen = 0;
        n    = 0;
        while (seen < k && n < 2000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen++;
        end
        if (seen < k) check_eq(tag, seen, k);
    endtask

    task automatic check_init_log(input int base, input string tag);
        for (int k = 0; k < 4; k++) check_eq(tag, log1[base + k], exp_init[k]);
    endtask

    initial begin
        int          n, base, vbase, changed;
        logic [7:0]  a;

        rst = 1'b1; int_1 = 1'b0; int_2 = 1'b0; reinit = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_wrt", wrt, 1'b0);
        check_eq("rst_vld", vld, 1'b0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        check_eq("rst_data", data, 80'h0);
        check_eq("rst_cmd", cmd, 16'h0D02);
        check_eq("rst_data2", data2, 32'h0);

        // Power-up wait and configuration list
        rst = 1'b0;
        wait_wrt(n);
        check_eq("first_wrt_cycle", n, 15);
        check_eq("first_cmd", cmd, 16'h0D02);
        wait_init("init_done_1");
        check_init_log(0, "init_cmd_1");
        check_eq("init_wrt_count", wr_n, 4);

        // Watchdog: 64 idle cycles with INT low
        repeat (63) @(negedge clk);
        check_eq("wdog_63", timeout, 1'b0);
        @(negedge clk);
        check_eq("wdog_64", timeout, 1'b1);
        check_eq("no_extra_wrt", wr_n, 4);

        // Frame 1: bytes 01..0A
        base = wr_n; vbase = vld_n;
        int_1 = 1'b1;
        @(negedge clk);
        check_eq("int_sync_1", wrt, 1'b0);
        @(negedge clk);
        check_eq("int_sync_2", wrt, 1'b1);
        check_eq("frame_cmd0", cmd, 16'hA200);
        int_1 = 1'b0;
        wait_done_n(5, "frame1_done5_timeout");
        check_eq("data_hold_mid", data, 80'h0);
        wait_done_n(5, "frame1_done10_timeout");
        check_eq("data_hold_last", data, 80'h0);
        check_eq("vld_before", vld, 1'b0);
        @(negedge clk);
        check_eq("frame1_vld", vld, 1'b1);
        check_eq("frame1_data", data, 80'h0A09_0807_0605_0403_0201);
        check_eq("frame1_ch0", data[15:0], 16'h0201);
        @(negedge clk);
        check_eq("frame1_vld_pulse", vld, 1'b0);
        check_eq("frame1_vld_count", vld_n - vbase, 1);
        check_eq("frame1_wrt_count", wr_n - base, 10);
        for (int k = 0; k < 10; k++) begin
            a = 8'hA2 + 8'(k);
            check_eq("frame1_cmd", log1[base + k], {a, 8'h00});
        end
        check_eq("timeout_sticky", timeout, 1'b1);

        // reinit from IDLE
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        check_eq("reinit_timeout_clr", timeout, 1'b0);
        check_eq("reinit_init_done_clr", init_done, 1'b0);
        base = wr_n;
        wait_wrt(n);
        check_eq("reinit_wrt_cycle", n, 15);
        check_eq("reinit_cmd", cmd, 16'h0D02);
        wait_init("init_done_2");
        check_init_log(base, "init_cmd_2");

        // reinit together with the 3rd done of a frame
        seed = 8'h10; base = wr_n; vbase = vld_n;
        int_1 = 1'b1;
        repeat (2) @(negedge clk);
        int_1 = 1'b0;
        wait_done_n(3, "abort_done3_timeout");
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        check_eq("abort_init_done", init_done, 1'b0);
        check_eq("abort_wrt_count", wr_n - base, 3);
        wait_wrt(n);
        check_eq("abort_wrt_cycle", n, 15);
        check_eq("abort_cmd", cmd, 16'h0D02);
        check_eq("abort_no_vld", vld_n - vbase, 0);
        check_eq("abort_data_kept", data, 80'h0A09_0807_0605_0403_0201);
        wait_init("init_done_3");

        // reinit together with the final done
        seed = 8'h20; base = wr_n;
        int_1 = 1'b1;
        repeat (2) @(negedge clk);
        int_1 = 1'b0;
        wait_done_n(10, "final_done10_timeout");
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        check_eq("final_vld", vld, 1'b1);
        check_eq("final_data", data, 80'h2A29_2827_2625_2423_2221);
        check_eq("final_init_done", init_done, 1'b0);
        check_eq("final_wrt_count", wr_n - base, 10);
        @(negedge clk);
        check_eq("final_vld_pulse", vld, 1'b0);
        wait_wrt(n);
        check_eq("final_reinit_wrt_cycle", n + 1, 15);
        wait_init("init_done_4");
        check_init_log(base + 10, "init_cmd_4");
        check_eq("final_total_wrt", wr_n - base, 14);

        // Two-channel instance: address wrap past 8'hFF
        check_eq("dut2_init_done", init_done2, 1'b1);
        base = wr2_n;
        int_2 = 1'b1;
        repeat (2) @(negedge clk);
        int_2 = 1'b0;
        changed = 0;
        n = 0;
        while (vld2 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (vld2 !== 1'b1 && data2 !== 32'h0) changed++;
        end
        check_eq("dut2_data_hold", changed, 0);
        check_eq("dut2_vld", vld2, 1'b1);
        check_eq("dut2_data", data2, 32'h0403_0201);
        check_eq("dut2_wrt_count", wr2_n - base, 4);
        check_eq("dut2_cmd0", log2[base],     16'hFE00);
        check_eq("dut2_cmd1", log2[base + 1], 16'hFF00);
        check_eq("dut2_cmd2", log2[base + 2], 16'h0000);
        check_eq("dut2_cmd3", log2[base + 3], 16'h0100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
